// File: rtl/dct2_seq_pkg.sv
// Shared types and constants for the 1-D DCT-II job sequencer.
package dct2_seq_pkg;

    localparam int LANES  = 32;
    localparam int SAMP_W = 16;
    localparam int ROWS_W = 5;

    typedef enum logic [1:0] {SZ32 = 2'd0, SZ16 = 2'd1, SZ8 = 2'd2, SZ4 = 2'd3} size_e;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

    function automatic logic [6:0] size_to_lanes(size_e s);
        case (s)
            SZ32:    return 7'd32;
            SZ16:    return 7'd16;
            SZ8:     return 7'd8;
            default: return 7'd4;
        endcase
    endfunction

endpackage

// File: rtl/dct2_1d_seq_if.sv
// Bus bundle between the sequencer, its job/row producers, the DCT core and the result consumer.
interface dct2_1d_seq_if;
    import dct2_seq_pkg::*;

    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [1:0]              cfg_size;
    logic [ROWS_W-1:0]       cfg_rows_m1;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*SAMP_W-1:0] in_data;
    logic [LANES*SAMP_W-1:0] core_x;
    logic [1:0]              core_n;
    logic [LANES*SAMP_W-1:0] core_y;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*SAMP_W-1:0] out_data;
    logic                    out_last;
    logic                    done;
    logic                    busy;

    modport slave (
        input  cfg_valid, cfg_size, cfg_rows_m1, in_valid, in_data, core_y, out_ready,
        output cfg_ready, in_ready, core_x, core_n, out_valid, out_data, out_last, done, busy
    );

    modport master (
        output cfg_valid, cfg_size, cfg_rows_m1, in_valid, in_data, core_y, out_ready,
        input  cfg_ready, in_ready, core_x, core_n, out_valid, out_data, out_last, done, busy
    );

endinterface

// File: rtl/dct2_seq_slice.sv
// Single valid/ready register slice; accepts a new word in the same cycle the held one leaves.
module dct2_seq_slice #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready_o  = ~vld_q | out_ready_i;
    assign out_valid_o = vld_q;
    assign out_data_o  = data_q;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (in_valid_i && in_ready_o) begin
            vld_d  = 1'b1;
            data_d = in_data_i;
        end else if (out_ready_i) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/dct2_1d_seq.sv
// Job sequencer around the external combinational multi-size 1-D DCT-II core.
// DCT2_SEQ_PIPE_EN adds a register stage in front of core_x (latency 2 instead of 1).
module dct2_1d_seq
    import dct2_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    dct2_1d_seq_if.slave bus
);
    localparam int DW = LANES * SAMP_W;

    state_e            state_q, state_d;
    size_e             size_q, size_d;
    logic [ROWS_W-1:0] rows_q, rows_d, cnt_q, cnt_d;
    logic              done_q, done_d;

    logic          is_last, in_fire, out_fire, last_move;
    logic [6:0]    n_lanes;
    logic [DW-1:0] x_mask;
    logic          o_in_vld, o_in_last, o_rdy;
    logic [DW:0]   o_q;

    assign n_lanes  = size_to_lanes(size_q);
    assign is_last  = (cnt_q == rows_q);
    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_mask
        localparam logic [6:0] IDX = 7'(i);
        assign x_mask[i*SAMP_W +: SAMP_W] = (IDX < n_lanes) ? bus.in_data[i*SAMP_W +: SAMP_W] : '0;
    end

`ifdef DCT2_SEQ_PIPE_EN
    logic          s1_vld, s1_rdy;
    logic [DW:0]   s1_q;

    dct2_seq_slice #(.W(DW + 1)) u_s1 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_fire), .in_ready_o(s1_rdy), .in_data_i({is_last, x_mask}),
        .out_valid_o(s1_vld), .out_ready_i(o_rdy), .out_data_o(s1_q)
    );

    // Once the last row sits in stage 1, no further row may enter behind it.
    assign bus.in_ready = (state_q == RUN) & s1_rdy & ~(s1_vld & s1_q[DW]);
    assign bus.core_x   = s1_q[DW-1:0];
    assign o_in_vld     = s1_vld;
    assign o_in_last    = s1_q[DW];
    assign last_move    = s1_vld & s1_q[DW] & o_rdy;
`else
    assign bus.in_ready = (state_q == RUN) & o_rdy;
    assign bus.core_x   = x_mask;
    assign o_in_vld     = in_fire;
    assign o_in_last    = is_last;
    assign last_move    = in_fire & is_last;
`endif

    dct2_seq_slice #(.W(DW + 1)) u_out (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(o_in_vld), .in_ready_o(o_rdy), .in_data_i({o_in_last, bus.core_y}),
        .out_valid_o(bus.out_valid), .out_ready_i(bus.out_ready), .out_data_o(o_q)
    );

    assign bus.out_data  = o_q[DW-1:0];
    assign bus.out_last  = o_q[DW];
    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.core_n    = size_q;
    assign bus.done      = done_q;

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        rows_d  = rows_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.cfg_valid) begin
                size_d  = size_e'(bus.cfg_size);
                rows_d  = bus.cfg_rows_m1;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // Count saturates on the final row so a 32-row job never wraps.
                if (in_fire && !is_last) cnt_d = cnt_q + 1'b1;
                if (last_move) state_d = DRAIN;
            end
            DRAIN: if (out_fire && bus.out_last) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            size_q  <= SZ32;
            rows_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            rows_q  <= rows_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule
